// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 32;

  // Quotient reported for a zero divisor; sliced down to the instance width.
  localparam logic [63:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/restoring_div_step.sv
// One restoring-division step: trial subtract of the divisor from the shifted
// partial remainder, keeping the difference only when no borrow ripples out.
module restoring_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_t,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit,
  output logic             o_borrow
);

  logic [WIDTH-1:0] w_diff;
  logic             w_borrowChain;

  // The top bit of the subtrahend is zero, so the last stage only propagates
  // the borrow; its difference bit is never needed because a kept result is
  // always smaller than the divisor.
  always_comb begin
    w_diff        = '0;
    w_borrowChain = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      w_diff[i]     = i_t[i] ^ i_divisor[i] ^ w_borrowChain;
      w_borrowChain = (~i_t[i] & i_divisor[i]) |
                      (~(i_t[i] ^ i_divisor[i]) & w_borrowChain);
    end
    w_borrowChain = ~i_t[WIDTH] & w_borrowChain;
  end

  assign o_borrow = w_borrowChain;
  assign o_qbit   = ~w_borrowChain;
  assign o_rem    = w_borrowChain ? i_t[WIDTH-1:0] : w_diff;

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, with
// valid/ready handshakes on the operand and result sides.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic             r_inReady;
  logic             r_outValid;
  logic             r_dbz;

  logic [WIDTH:0]   w_t;
  logic [WIDTH-1:0] w_nextRem;
  logic             w_qbit;
  logic             w_borrow;

  // The dividend is shifted out of the quotient register MSB-first as the
  // quotient bits are shifted in from the bottom.
  assign w_t = {r_rem, r_quo[WIDTH-1]};

  restoring_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_t       (w_t),
    .i_divisor (r_divisor),
    .o_rem     (w_nextRem),
    .o_qbit    (w_qbit),
    .o_borrow  (w_borrow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_dbz      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_divisor <= divisor;
            r_inReady <= 1'b0;
            r_state   <= BUSY;
            // A zero divisor spends a single BUSY cycle holding the fixed result.
            if (divisor == '0) begin
              r_quo <= DBZ_QUOTIENT[WIDTH-1:0];
              r_rem <= dividend;
              r_cnt <= CNT_W'(1);
              r_dbz <= 1'b1;
            end else begin
              r_quo <= dividend;
              r_rem <= '0;
              r_cnt <= CNT_W'(WIDTH);
              r_dbz <= 1'b0;
            end
          end
        end
        BUSY: begin
          if (!r_dbz) begin
            r_rem <= w_nextRem;
            r_quo <= {r_quo[WIDTH-2:0], w_qbit};
          end
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state    <= DONE;
            r_outValid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state    <= IDLE;
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_outValid <= 1'b0;
          r_inReady  <= 1'b1;
        end
      endcase
    end
  end

  // The step's quotient bit and borrow are complementary by construction.
  always_ff @(posedge clk) begin
    if (!rst && r_state == BUSY && !r_dbz) begin
      assert (w_qbit == !w_borrow);
    end
  end

  assign in_ready    = r_inReady;
  assign out_valid   = r_outValid;
  assign quotient    = r_quo;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
Multi-cycle unsigned integer divider built around a WIDTH+1-bit subtract-with-borrow step, one quotient bit per clock. It sits directly downstream of the datapath's ripple subtractor stage. It consumes the subtract result and borrow-out each cycle to decide restore or keep. It exposes valid/ready handshakes on operand input and result output for use by the ALU control sequencer.

Parameters:
WIDTH, 32, operand/quotient/remainder width in bits (legal range 2..64)
CNT_W, $clog2(WIDTH+1), step-counter width (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands presented
in_ready  output  1  block can accept operands (high only in IDLE)
dividend  input  WIDTH  unsigned dividend
divisor  input  WIDTH  unsigned divisor
out_valid  output  1  result presented
out_ready  input  1  consumer accepts result
quotient  output  WIDTH  unsigned quotient
remainder  output  WIDTH  unsigned remainder
div_by_zero  output  1  result came from a zero divisor

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. rst sampled high at a rising edge forces the reset state regardless of other inputs.
- Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, step counter=0.
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. Accept when in_valid&&in_ready at an edge, and latch dividend and divisor.
  - If divisor==0: go to DONE next edge with quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
  - Else: go to BUSY with partial remainder R=0, Q=dividend, counter=WIDTH, div_by_zero=0.
- BUSY: in_ready=0, out_valid=0. Each edge performs one step:
  - T = {R, Q[WIDTH-1]}, width WIDTH+1.
  - diff = T - {1'b0, divisor}, computed WIDTH+1 bits wide with borrow-out.
  - If borrow==0: R=diff[WIDTH-1:0] and the new quotient bit is 1.
  - Else: R=T[WIDTH-1:0] (restore) and the new quotient bit is 0.
  - Q={Q[WIDTH-2:0], qbit}; counter decrements.
  - When counter reaches 1 on a step edge, that edge also moves to DONE.
- Latency: out_valid rises exactly WIDTH edges after the accept edge, or 1 edge for divide-by-zero.
- DONE: out_valid=1. quotient=Q and remainder=R, held stable while out_ready=0 (backpressure, no timeout). On an edge with out_ready=1, go to IDLE; out_valid drops the next cycle. No overlap: a new accept is possible only from IDLE, so the minimum initiation interval is WIDTH+2 cycles.
- in_valid during BUSY or DONE is ignored; the operand registers must not change.
- quotient and remainder are registered outputs. Their value outside DONE is don't-care, but it must be deterministic and must not be X after reset.
- Reset mid-BUSY or mid-DONE aborts the operation with no output: out_valid=0 on the following cycle and no partial result is emitted.
- Invariants when out_valid=1 and div_by_zero=0: dividend == quotient*divisor + remainder, and remainder < divisor.

Decomposition:
- Shared package div_pkg holds:
  - state enum div_state_t {IDLE, BUSY, DONE}
  - localparam DIV_WIDTH_DEFAULT=32
  - constant for the divide-by-zero quotient pattern
- One sub-module: restoring_div_step, purely combinational.
  - Inputs: T (WIDTH+1 bits) and divisor.
  - Outputs: next R, qbit, borrow.
  - Internally a WIDTH+1-bit borrow-ripple subtract.
- The top level holds the FSM, counter, R/Q registers and handshakes.

Test Plan:
- Basic: accept 100/7 with out_ready=1 -> out_valid exactly 32 edges after accept; quotient=14, remainder=2, div_by_zero=0; in_ready low for 33 cycles total.
- Edge operands:
  - 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
  - 0xFFFFFFFF/0xFFFFFFFF -> q=1, r=0.
  - 5/9 -> q=0, r=5.
  - 0/3 -> q=0, r=0.
- Divide-by-zero: 1234/0 -> out_valid 1 edge after accept; q=0xFFFFFFFF, r=1234, div_by_zero=1. A following 10/3 -> q=3, r=1, div_by_zero=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0; in_valid pulses with other operands are ignored; release -> IDLE next cycle.
- Reset mid-op: assert rst at step 15 of 200/3 -> next cycle IDLE, in_ready=1, out_valid=0. Then 200/3 -> q=66, r=2.
- Random regression: 10k random pairs plus back-to-back accepts -> check the invariants against a reference model; throughput is one result per WIDTH+2 cycles with out_ready tied high.
